tokens_pack: RTL



---
 rtl/tokens_pkg.sv | 22 ++
 rtl/tokens_preg.sv | 31 +++
 rtl/tokens_pack.sv | 113 +++++++++++
 3 files changed

// File: rtl/tokens_pkg.sv
// tokens_pkg: helpers shared by the tokens_* blocks.
//   tokens_clog2_min1(n) : ceil(log2(n)), never less than 1, used to size counters.
//   tokens_therm(n, w)   : thermometer code with bits 0..min(n,w)-1 set.
//                          The result is TOKENS_MAX_LANES wide; callers size-cast it.
package tokens_pkg;

    localparam int TOKENS_MAX_LANES = 64;

    function automatic int tokens_clog2_min1(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [TOKENS_MAX_LANES-1:0] tokens_therm(int n, int width);
        logic [TOKENS_MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < TOKENS_MAX_LANES; i++) begin
            if (i < n && i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tokens_preg.sv
// tokens_preg: one-deep valid/payload output register.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and payload)
//   load       : capture nxt and raise vld (takes priority over clear)
//   clear      : drop vld, payload holds its last value
//   nxt        : payload to capture
//   vld, dat   : registered valid and payload
module tokens_preg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] nxt,
    output logic          vld,
    output logic [DW-1:0] dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= nxt;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/tokens_pack.sv
// tokens_pack: width up-converter, packs RATIO narrow DW-bit beats into one
// RATIO*DW word, lane 0 first. A beat with src_lst closes the word early and
// the unused upper lanes are zero with dst_msk marking the valid lanes.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   src_vld, src_rdy, src_dat, src_lst: narrow input beat
//   dst_vld, dst_rdy                  : packed word handshake (registered)
//   dst_dat                           : packed word, lane k = [k*DW +: DW]
//   dst_msk                           : thermometer lane mask from bit 0
//   dst_lst                           : word was closed by src_lst
//
// Handshake: a transfer happens on a rising edge where vld & rdy are both 1.
// A source holds its data stable while vld=1 and rdy=0. src_rdy depends only
// on registered dst_vld and on dst_rdy, never on src_vld or src_dat.
module tokens_pack
    import tokens_pkg::*;
#(
    parameter int DW    = 8,
    parameter int RATIO = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                src_vld,
    output logic                src_rdy,
    input  logic [DW-1:0]       src_dat,
    input  logic                src_lst,
    output logic                dst_vld,
    input  logic                dst_rdy,
    output logic [RATIO*DW-1:0] dst_dat,
    output logic [RATIO-1:0]    dst_msk,
    output logic                dst_lst
);

    localparam int CW = tokens_clog2_min1(RATIO);
    localparam int PW = RATIO*DW + RATIO + 1;

    if (RATIO < 1) begin : g_ratio_check
        $error("tokens_pack: RATIO must be at least 1");
    end

    logic          acc_en;
    logic          emit;
    logic          last_lane;
    logic          close;
    logic [CW-1:0] cnt;

    logic [RATIO*DW-1:0] word_nxt;
    logic [RATIO-1:0]    msk_nxt;
    logic [PW-1:0]       pay_nxt;
    logic [PW-1:0]       pay;

    assign src_rdy   = ~dst_vld | dst_rdy;
    assign acc_en    = src_vld & src_rdy;
    assign emit      = dst_vld & dst_rdy;
    assign last_lane = (cnt == CW'(RATIO-1));
    assign close     = acc_en & (last_lane | src_lst);

    // cnt is the lane the next accepted beat lands in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (close) begin
            cnt <= '0;
        end else if (acc_en) begin
            cnt <= cnt + CW'(1);
        end
    end

    if (RATIO > 1) begin : g_acc
        // The top lane is never stored: a beat landing there always closes.
        // Lanes are not cleared on close; the zero-forcing below hides stale data.
        logic [(RATIO-1)*DW-1:0] acc;

        always_ff @(posedge clk) begin
            for (int k = 0; k < RATIO-1; k++) begin
                if (acc_en && !close && cnt == CW'(k)) begin
                    acc[k*DW +: DW] <= src_dat;
                end
            end
        end

        for (genvar k = 0; k < RATIO; k++) begin : g_lane
            if (k < RATIO-1) begin : g_stored
                assign word_nxt[k*DW +: DW] = (CW'(k) < cnt)  ? acc[k*DW +: DW] :
                                              (CW'(k) == cnt) ? src_dat : '0;
            end else begin : g_top
                assign word_nxt[k*DW +: DW] = (CW'(k) == cnt) ? src_dat : '0;
            end
        end
    end else begin : g_no_acc
        assign word_nxt = src_dat;
    end

    // Lanes 0..cnt are valid in the closing word.
    assign msk_nxt = RATIO'(tokens_therm(int'(cnt) + 1, RATIO));
    assign pay_nxt = {src_lst, msk_nxt, word_nxt};

    // A close only happens when src_rdy is 1, so a load never overwrites a
    // stalled word; load-with-emit reloads and keeps dst_vld high.
    tokens_preg #(
        .DW (PW)
    ) u_preg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (close),
        .clear (emit),
        .nxt   (pay_nxt),
        .vld   (dst_vld),
        .dat   (pay)
    );

    assign {dst_lst, dst_msk, dst_dat} = pay;

endmodule
